// File: rtl/logic_unit_seq.sv
// Chunk-serial bitwise logic unit: applies one of eight logic ops CHUNK bits per
// cycle, LSB chunk first, and reports the result with popcount, zero and parity flags.
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             In1,
    input  logic [WIDTH-1:0]             In2,
    input  logic [2:0]                   Op,
    output logic [WIDTH-1:0]             cout1,
    output logic [$clog2(WIDTH+1)-1:0]   ones,
    output logic                         zero,
    output logic                         parity,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] work_q;
    logic [CW-1:0]    acc_q;
    logic [WIDTH-1:0] cout1_q;
    logic [CW-1:0]    ones_q;
    logic             zero_q;
    logic             parity_q;
    logic             out_valid_q;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_res;
    logic [WIDTH-1:0] work_d;
    logic [CW-1:0]    acc_d;
    logic             last_chunk;
    logic             take;

    function automatic logic [CHUNK-1:0] logic_op(
        input logic [2:0]       op,
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] b
    );
        logic [CHUNK-1:0] r;
        case (op)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a ^ b;
            3'b011:  r = ~(a | b);
            3'b100:  r = ~(a ^ b);
            3'b101:  r = a & ~b;
            3'b110:  r = a;
            default: r = ~a;
        endcase
        return r;
    endfunction

    function automatic logic [CW-1:0] popcnt(input logic [CHUNK-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < CHUNK; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign take     = in_valid && in_ready;

    // Select chunk k of the operands and merge its result into the working word.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                chunk_a = a_q[i*CHUNK +: CHUNK];
                chunk_b = b_q[i*CHUNK +: CHUNK];
            end
        end
        chunk_res = logic_op(op_q, chunk_a, chunk_b);
        work_d    = work_q;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                work_d[i*CHUNK +: CHUNK] = chunk_res;
            end
        end
        acc_d      = acc_q + popcnt(chunk_res);
        last_chunk = (k_q == KW'(N - 1));
    end

    // Operand registers carry data only; they are qualified by the FSM state.
    always_ff @(posedge clk) begin
        if (take) begin
            a_q  <= In1;
            b_q  <= In2;
            op_q <= Op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            work_q      <= '0;
            acc_q       <= '0;
            cout1_q     <= '0;
            ones_q      <= '0;
            zero_q      <= 1'b0;
            parity_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take) begin
                        work_q  <= '0;
                        acc_q   <= '0;
                        k_q     <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    work_q <= work_d;
                    acc_q  <= acc_d;
                    if (last_chunk) begin
                        cout1_q     <= work_d;
                        ones_q      <= acc_d;
                        zero_q      <= (work_d == '0);
                        parity_q    <= acc_d[0];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            work_q  <= '0;
                            acc_q   <= '0;
                            k_q     <= '0;
                            state_q <= BUSY;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cout1     = cout1_q;
    assign ones      = ones_q;
    assign zero      = zero_q;
    assign parity    = parity_q;
    assign out_valid = out_valid_q;

endmodule
